// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - hazard detection, forwarding and mult/div stall control for a 5-stage MIPS pipeline
//
// Purpose:
//   Generates the fetch enable, decode hold and execute flush for load-use,
//   branch-in-decode and HI/LO-pending hazards. Produces operand forwarding
//   selects for the execute ALU and the decode branch comparator. Tracks the
//   multi-cycle mult/div unit with a two-state FSM.
//
// Optional feature (macro STALL_COUNTER_EN):
//   defined   - stallCount counts stalled cycles and saturates at all-ones
//   undefined - no counter register; stallCount is tied to 0
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   rsD, rtD / rsE, rtE             decode / execute source registers
//   writeRegE/M/W, regWriteE/M/W    destination register and write enable per stage
//   memToRegE, memToRegM            load in execute / memory
//   branchD                         branch resolved in decode
//   mdStartE                        mult/div issued in execute (1-cycle pulse)
//   mdUseD                          decode instruction reads HI/LO
//   enF, stallD, flushE             PC enable, decode hold, execute clear
//   forwardAD, forwardBD            ALUOutM to branch comparator
//   forwardAE, forwardBE            00 = RF, 10 = ALUOutM, 01 = ResultW
//   mdBusy                          mult/div in progress
//   stallCount                      stall-cycle counter
module hazard_stall_unit #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeRegE,
  input  logic [4:0]       writeRegM,
  input  logic [4:0]       writeRegW,
  input  logic             regWriteE,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             memToRegE,
  input  logic             memToRegM,
  input  logic             branchD,
  input  logic             mdStartE,
  input  logic             mdUseD,
  output logic             enF,
  output logic             stallD,
  output logic             flushE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam logic [3:0] MD_RELOAD = 4'(MD_LATENCY - 1);

  md_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic       lwstall, branchstall, mdstall, stall;
  logic       fwd_ad, fwd_bd;
  logic [1:0] fwd_ae, fwd_be;

  // Mult/div tracking FSM

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mdStartE) begin
          state_d = BUSY;
          cnt_d   = MD_RELOAD;
        end
      end
      BUSY: begin
        // A new issue is only accepted in the final busy cycle; earlier
        // issues are a protocol error and are dropped.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (mdStartE) begin
          cnt_d = MD_RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Forwarding and hazard detection

  always_comb begin
    fwd_ae = 2'b00;
    if (rsE != 5'd0 && rsE == writeRegM && regWriteM) begin
      fwd_ae = 2'b10;
    end else if (rsE != 5'd0 && rsE == writeRegW && regWriteW) begin
      fwd_ae = 2'b01;
    end

    fwd_be = 2'b00;
    if (rtE != 5'd0 && rtE == writeRegM && regWriteM) begin
      fwd_be = 2'b10;
    end else if (rtE != 5'd0 && rtE == writeRegW && regWriteW) begin
      fwd_be = 2'b01;
    end

    fwd_ad = (rsD != 5'd0) && (rsD == writeRegM) && regWriteM;
    fwd_bd = (rtD != 5'd0) && (rtD == writeRegM) && regWriteM;

    // Register 0 is intentionally not excluded here: costs a spare bubble only.
    lwstall = memToRegE && ((rtE == rsD) || (rtE == rtD));

    branchstall = branchD &&
                  ((regWriteE && ((writeRegE == rsD) || (writeRegE == rtD))) ||
                   (memToRegM && ((writeRegM == rsD) || (writeRegM == rtD))));

    // The issue cycle itself counts as busy for a dependent decode.
    mdstall = mdUseD && ((state_q == BUSY) || mdStartE);

    stall = lwstall | branchstall | mdstall;
  end

  // Reset forces a benign pipeline view regardless of the inputs.
  always_comb begin
    enF       = 1'b1;
    stallD    = 1'b0;
    flushE    = 1'b0;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    mdBusy    = 1'b0;
    if (!reset) begin
      enF       = ~stall;
      stallD    = stall;
      flushE    = stall;
      forwardAD = fwd_ad;
      forwardBD = fwd_bd;
      forwardAE = fwd_ae;
      forwardBE = fwd_be;
      mdBusy    = (state_q == BUSY);
    end
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
`else
  assign stallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic       rwE, rwM, rwW, m2rE, m2rM, brD, mdS, mdU;
  } in_t;

  // out bits: {enF, stallD, flushE, fAD, fBD, fAE[1:0], fBE[1:0], mdBusy}
  typedef struct {
    in_t         in;
    logic [9:0]  exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [9:0]       exp;
    logic [CNT_W-1:0] cnt;
    string            name;
  } sb_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic             regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
  logic             branchD, mdStartE, mdUseD;
  logic             enF, stallD, flushE, forwardAD, forwardBD, mdBusy;
  logic [1:0]       forwardAE, forwardBE;
  logic [CNT_W-1:0] stallCount;

  int               n_vec = 0;
  int               n_bad = 0;
  int               cnt_model = 0;
  vec_t             tbl[$];
  sb_t              sb[$];

  always #5 clk = ~clk;

  hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM),
    .branchD(branchD), .mdStartE(mdStartE), .mdUseD(mdUseD),
    .enF(enF), .stallD(stallD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mdBusy(mdBusy), .stallCount(stallCount)
  );

  function automatic logic [9:0] mko(input logic st, input logic fad, input logic fbd,
                                     input logic [1:0] fae, input logic [1:0] fbe,
                                     input logic busy);
    return {~st, st, st, fad, fbd, fae, fbe, busy};
  endfunction

  function automatic in_t z();
    return '0;
  endfunction

  task automatic add(input in_t i, input logic [9:0] e, input string nm);
    vec_t v;
    v.in = i; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endtask

  // Drive one cycle of stimulus, queue its expectation, check mid-cycle.
  task automatic step(input in_t i, input logic rst, input logic [9:0] e, input string nm);
    sb_t s, g;
    logic [9:0] act;
    @(posedge clk);
    #1;
    rsD = i.rsD; rtD = i.rtD; rsE = i.rsE; rtE = i.rtE;
    writeRegE = i.wE; writeRegM = i.wM; writeRegW = i.wW;
    regWriteE = i.rwE; regWriteM = i.rwM; regWriteW = i.rwW;
    memToRegE = i.m2rE; memToRegM = i.m2rM; branchD = i.brD;
    mdStartE = i.mdS; mdUseD = i.mdU;
    reset = rst;
    if (rst) cnt_model = 0;
    s.exp = e; s.cnt = CNT_W'(cnt_model); s.name = nm;
    sb.push_back(s);
    @(negedge clk);
    g = sb.pop_front();
    act = {enF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE, mdBusy};
    n_vec++;
    if (act !== g.exp || stallCount !== g.cnt) begin
      n_bad++;
      $display("FAIL %s: got out=%b cnt=%0d, expected out=%b cnt=%0d",
               g.name, act, stallCount, g.exp, g.cnt);
    end
`ifdef STALL_COUNTER_EN
    if (!rst && e[8] && cnt_model < (1 << CNT_W) - 1) cnt_model++;
`endif
  endtask

  localparam logic [9:0] FREE = 10'b100_0_0_00_00_0;
  localparam logic [9:0] STL  = 10'b011_0_0_00_00_0;

  initial begin
    in_t i;

    // ---- vector table ----
    i = z();                                                       add(i, FREE, "idle");
    i = z(); i.m2rE = 1; i.rtE = 8; i.rsD = 8;                      add(i, STL, "loaduse_rs");
    i = z(); i.m2rE = 1; i.rtE = 9; i.rtD = 9; i.rsD = 1;           add(i, STL, "loaduse_rt");
    i = z(); i.m2rE = 1; i.rtE = 9; i.rsD = 1; i.rtD = 2;           add(i, FREE, "load_no_dep");
    i = z(); i.m2rE = 1;                                           add(i, STL, "loaduse_r0_bubble");
    i = z(); i.rsE = 5; i.wM = 5; i.rwM = 1; i.wW = 5; i.rwW = 1;   add(i, mko(0,0,0,2'b10,2'b00,0), "fwdAE_M_prio");
    i = z(); i.rsE = 5; i.wM = 5; i.rwM = 0; i.wW = 5; i.rwW = 1;   add(i, mko(0,0,0,2'b01,2'b00,0), "fwdAE_W");
    i = z(); i.rsE = 0; i.wM = 0; i.rwM = 1; i.wW = 0; i.rwW = 1;   add(i, FREE, "fwdAE_r0");
    i = z(); i.rtE = 7; i.wM = 7; i.rwM = 1;                        add(i, mko(0,0,0,2'b00,2'b10,0), "fwdBE_M");
    i = z(); i.rtE = 7; i.wW = 7; i.rwW = 1; i.wM = 6; i.rwM = 1;   add(i, mko(0,0,0,2'b00,2'b01,0), "fwdBE_W");
    i = z(); i.rsD = 3; i.rtD = 4; i.wM = 3; i.rwM = 1;             add(i, mko(0,1,0,2'b00,2'b00,0), "fwdAD");
    i = z(); i.rsD = 3; i.rtD = 4; i.wM = 4; i.rwM = 1;             add(i, mko(0,0,1,2'b00,2'b00,0), "fwdBD");
    i = z(); i.rwM = 1;                                            add(i, FREE, "fwdD_r0");
    i = z(); i.brD = 1; i.rsD = 3; i.wE = 3; i.rwE = 1;             add(i, STL, "branch_dep_E");
    i = z(); i.brD = 1; i.rsD = 3; i.wE = 3; i.rwE = 0;             add(i, FREE, "branch_E_nowrite");
    i = z(); i.brD = 1; i.rsD = 3; i.wM = 3; i.rwM = 1;             add(i, mko(0,1,0,2'b00,2'b00,0), "branch_M_alu");
    i = z(); i.brD = 1; i.rsD = 1; i.rtD = 6; i.wM = 6; i.rwM = 1; i.m2rM = 1;
                                                                   add(i, mko(1,0,1,2'b00,2'b00,0), "branch_M_load");
    i = z(); i.mdU = 1;                                            add(i, FREE, "mduse_idle");
    i = z(); i.m2rE = 1; i.rtE = 8; i.rsD = 8; i.brD = 1; i.wE = 8; i.rwE = 1;
                                                                   add(i, STL, "lw_and_branch");

    // ---- reset state with hazard-provoking inputs ----
    i = z(); i.m2rE = 1; i.rtE = 8; i.rsD = 8; i.rsE = 5; i.wM = 5; i.rwM = 1;
    step(i, 1'b1, FREE, "reset_forced");
    step(z(), 1'b0, FREE, "after_reset");

    foreach (tbl[k]) step(tbl[k].in, 1'b0, tbl[k].exp, tbl[k].name);

    // ---- load-use lasts exactly one cycle ----
    i = z(); i.m2rE = 1; i.rtE = 8; i.rsD = 8;
    step(i, 1'b0, STL, "lu_seq_stall");
    i.m2rE = 0;
    step(i, 1'b0, FREE, "lu_seq_release");

    // ---- branch stalls then forwards from M ----
    i = z(); i.brD = 1; i.rsD = 3; i.wE = 3; i.rwE = 1;
    step(i, 1'b0, STL, "br_seq_stall");
    i = z(); i.brD = 1; i.rsD = 3; i.wM = 3; i.rwM = 1;
    step(i, 1'b0, mko(0,1,0,2'b00,2'b00,0), "br_seq_fwd");

    // ---- mult/div: issue, then HI/LO reader waits 4 busy cycles ----
    i = z(); i.mdS = 1;
    step(i, 1'b0, FREE, "md_issue");
    i = z(); i.mdU = 1;
    for (int c = 0; c < 4; c++) step(i, 1'b0, mko(1,0,0,2'b00,2'b00,1), "md_busy_stall");
    step(i, 1'b0, FREE, "md_done");

    // ---- mult/div: early issue ignored, issue on last busy cycle re-enters ----
    i = z(); i.mdS = 1;
    step(i, 1'b0, FREE, "md2_issue");
    step(z(), 1'b0, mko(0,0,0,2'b00,2'b00,1), "md2_b1");
    step(i,   1'b0, mko(0,0,0,2'b00,2'b00,1), "md2_b2_ignored");
    step(z(), 1'b0, mko(0,0,0,2'b00,2'b00,1), "md2_b3");
    step(i,   1'b0, mko(0,0,0,2'b00,2'b00,1), "md2_b4_reissue");
    for (int c = 0; c < 4; c++) step(z(), 1'b0, mko(0,0,0,2'b00,2'b00,1), "md2_rebusy");
    step(z(), 1'b0, FREE, "md2_idle");

    // ---- reset mid-BUSY aborts ----
    i = z(); i.mdS = 1;
    step(i, 1'b0, FREE, "mdr_issue");
    i = z(); i.mdU = 1;
    step(i, 1'b0, mko(1,0,0,2'b00,2'b00,1), "mdr_b1");
    step(i, 1'b1, FREE, "mdr_reset_b2");
    step(i, 1'b0, FREE, "mdr_after_reset");

    // ---- stall counter saturation, then reset ----
    i = z(); i.m2rE = 1; i.rtE = 8; i.rsD = 8;
    for (int c = 0; c < 20; c++) step(i, 1'b0, STL, "cnt_sat");
    step(z(), 1'b0, FREE, "cnt_hold");
    step(z(), 1'b1, FREE, "cnt_reset");
    step(z(), 1'b0, FREE, "cnt_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
